// File: rtl/pulse_generator_if.sv
// Control and status bundle for the pulse generator: width programming and
// run enable in, waveform and status strobes out.
interface pulse_generator_if #(
   parameter int COUNTER_BITS = 8
);
   logic                    en;
   logic                    load;
   logic [COUNTER_BITS-1:0] time_high;
   logic [COUNTER_BITS-1:0] time_low;
   logic                    freq_out;
   logic                    pulse;
   logic                    period_done;
   logic                    pending;
   logic                    busy;

   modport master (
      output en, load, time_high, time_low,
      input  freq_out, pulse, period_done, pending, busy
   );

   modport slave (
      input  en, load, time_high, time_low,
      output freq_out, pulse, period_done, pending, busy
   );
endinterface

// File: rtl/pulse_generator.sv
// Programmable high/low pulse-train generator. Staged widths are applied only
// at period boundaries, so the waveform never glitches.
module pulse_generator #(
   parameter int COUNTER_BITS = 8
) (
   input logic             CLK,
   input logic             RST_N,
   pulse_generator_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_e;

   localparam logic [COUNTER_BITS-1:0] ONE = COUNTER_BITS'(1);

   state_e                  state_q, state_d;
   logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
   logic [COUNTER_BITS-1:0] stg_hi_q, stg_hi_d;
   logic [COUNTER_BITS-1:0] stg_lo_q, stg_lo_d;
   logic [COUNTER_BITS-1:0] act_hi_q, act_hi_d;
   logic [COUNTER_BITS-1:0] act_lo_q, act_lo_d;
   logic                    pending_q, pending_d;
   logic                    freq_q, freq_d;
   logic                    pulse_q, pulse_d;

   logic [COUNTER_BITS-1:0] hi_eff, lo_eff;
   logic                    period_end;
   logic                    start;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path
      //       through this block can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      stg_hi_d  = stg_hi_q;
      stg_lo_d  = stg_lo_q;
      act_hi_d  = act_hi_q;
      act_lo_d  = act_lo_q;
      pending_d = pending_q;
      pulse_d   = 1'b0;

      // Boundary decisions see the staging content from before this edge.
      hi_eff = pending_q ? stg_hi_q : act_hi_q;
      lo_eff = pending_q ? stg_lo_q : act_lo_q;

      period_end = (state_q == S_LOW  && cnt_q == '0) ||
                   (state_q == S_HIGH && cnt_q == '0 && act_lo_q == '0);
      start = (state_q == S_IDLE && bus.en &&
               (pending_q || act_hi_q != '0 || act_lo_q != '0)) ||
              (period_end && bus.en);

      unique case (state_q)
         S_HIGH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end else if (act_lo_q != '0) begin
               state_d = S_LOW;
               cnt_d   = act_lo_q - ONE;
            end
         end
         S_LOW: begin
            if (cnt_q != '0) cnt_d = cnt_q - ONE;
         end
         default: ;
      endcase

      if (period_end && !bus.en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      if (start) begin
         if (pending_q) begin
            act_hi_d  = stg_hi_q;
            act_lo_d  = stg_lo_q;
            pending_d = 1'b0;
         end
         if (hi_eff != '0) begin
            state_d = S_HIGH;
            cnt_d   = hi_eff - ONE;
            pulse_d = 1'b1;
         end else if (lo_eff != '0) begin
            state_d = S_LOW;
            cnt_d   = lo_eff - ONE;
         end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      end

      // A LOAD on a boundary edge re-arms PENDING for the following boundary.
      if (bus.load) begin
         stg_hi_d  = bus.time_high;
         stg_lo_d  = bus.time_low;
         pending_d = 1'b1;
      end

      freq_d = (state_d == S_HIGH);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         stg_hi_q  <= '0;
         stg_lo_q  <= '0;
         act_hi_q  <= '0;
         act_lo_q  <= '0;
         pending_q <= 1'b0;
         freq_q    <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stg_hi_q  <= stg_hi_d;
         stg_lo_q  <= stg_lo_d;
         act_hi_q  <= act_hi_d;
         act_lo_q  <= act_lo_d;
         pending_q <= pending_d;
         freq_q    <= freq_d;
         pulse_q   <= pulse_d;
      end
   end

   assign bus.freq_out    = freq_q;
   assign bus.pulse       = pulse_q;
   assign bus.period_done = period_end;
   assign bus.pending     = pending_q;
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: expected waveforms come from the
// hi/lo phase pattern of the programmed widths.
module tb_pulse_generator;

   localparam int CB = 8;

   logic CLK = 1'b0;
   logic RST_N;
   int   checks   = 0;
   int   failures = 0;
   int   ph;

   pulse_generator_if #(.COUNTER_BITS(CB)) bus ();

   pulse_generator #(.COUNTER_BITS(CB)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_widths(input int hi, input int lo);
      bus.load      = 1'b1;
      bus.time_high = CB'(hi);
      bus.time_low  = CB'(lo);
   endtask

   // Checks n cycles of a hi/lo period starting at phase p, then advances p.
   task automatic run_wave(input int n, input int hi, input int lo, inout int p);
      for (int i = 0; i < n; i++) begin
         check("freq_out",    bus.freq_out,    32'(p < hi));
         check("pulse",       bus.pulse,       32'(p == 0 && hi != 0));
         check("period_done", bus.period_done, 32'(p == hi + lo - 1));
         p = (p + 1) % (hi + lo);
         tick();
         bus.load = 1'b0;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_freq"}, bus.freq_out,    0);
      check({tag, "_pulse"}, bus.pulse,      0);
      check({tag, "_done"}, bus.period_done, 0);
      check({tag, "_busy"}, bus.busy,        0);
   endtask

   initial begin
      RST_N         = 1'b0;
      bus.en        = 1'b0;
      bus.load      = 1'b0;
      bus.time_high = '0;
      bus.time_low  = '0;
      #1;
      tick();
      tick();
      check_idle("reset");
      check("reset_pending", bus.pending, 0);
      RST_N = 1'b1;

      // 3/5 waveform
      load_widths(3, 5);
      tick();
      bus.load = 1'b0;
      check("load_pending", bus.pending, 1);
      check("load_busy",    bus.busy,    0);
      check("load_freq",    bus.freq_out, 0);
      bus.en = 1'b1;
      tick();
      check("start_pending", bus.pending, 0);
      check("start_busy",    bus.busy,    1);
      ph = 0;
      run_wave(20, 3, 5, ph);

      // LOAD 1/1 in second LOW cycle; current period finishes as 3/5
      load_widths(1, 1);
      run_wave(1, 3, 5, ph);
      for (int i = 0; i < 3; i++) begin
         check("midload_pending", bus.pending, 1);
         run_wave(1, 3, 5, ph);
      end
      check("toggle_pending", bus.pending, 0);
      ph = 0;
      run_wave(6, 1, 1, ph);

      // back to 3/5, then EN drops in the second HIGH cycle
      load_widths(3, 5);
      run_wave(1, 1, 1, ph);
      check("reload_pending", bus.pending, 1);
      run_wave(1, 1, 1, ph);
      ph = 0;
      run_wave(1, 3, 5, ph);
      bus.en = 1'b0;
      run_wave(7, 3, 5, ph);
      check_idle("en_off");
      tick();
      check_idle("en_off2");
      bus.en = 1'b1;
      tick();
      ph = 0;
      run_wave(8, 3, 5, ph);

      // hi=4 lo=0: held high
      load_widths(4, 0);
      run_wave(8, 3, 5, ph);
      ph = 0;
      run_wave(8, 4, 0, ph);

      // hi=0 lo=4: held low, no PULSE
      load_widths(0, 4);
      run_wave(4, 4, 0, ph);
      ph = 0;
      run_wave(8, 0, 4, ph);

      // 255/255 full-range period, then 0/0 returns to IDLE
      load_widths(255, 255);
      run_wave(4, 0, 4, ph);
      ph = 0;
      run_wave(1, 255, 255, ph);
      load_widths(0, 0);
      run_wave(509, 255, 255, ph);
      check_idle("zero_idle");
      check("zero_pending", bus.pending, 0);
      tick();
      check_idle("zero_idle2");

      // reset mid-HIGH abandons the period
      load_widths(3, 5);
      tick();
      bus.load = 1'b0;
      check("pre_rst_pending", bus.pending, 1);
      tick();
      ph = 0;
      run_wave(1, 3, 5, ph);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check_idle("midrst");
      check("midrst_pending", bus.pending, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("post_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
